// File: rtl/parallel_biquad_bank.sv
// Parallel-form IIR bank: N_SECTIONS DF2T biquads evaluated one per clock on a shared
// 5-multiplier datapath, outputs summed with saturation into one sample.
module parallel_biquad_bank #(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int FRAC_BITS   = 14,
   parameter int N_SECTIONS  = 4,
   localparam int SW        = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1,
   localparam int ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  x_in,
   output logic                   out_valid,
   output logic [DATA_WIDTH-1:0]  y_out,
   input  logic [N_SECTIONS-1:0]  sec_enable,
   input  logic                   coef_we,
   input  logic [SW-1:0]          coef_sec,
   input  logic [2:0]             coef_sel,
   input  logic [COEFF_WIDTH-1:0] coef_data,
   input  logic                   flush,
   output logic                   busy,
   output logic                   ovf
);

   localparam int SUM_WIDTH = DATA_WIDTH + SW + 1;
   localparam int PW        = DATA_WIDTH + COEFF_WIDTH;

   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = {{(SUM_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [SUM_WIDTH-1:0] SUM_MIN = {{(SUM_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [DATA_WIDTH-1:0] D_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] D_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

   state_t                         state_q, state_d;
   logic [SW-1:0]                  cnt_q, cnt_d;
   logic signed [DATA_WIDTH-1:0]   x_q, x_d;
   logic [N_SECTIONS-1:0]          en_q, en_d;
   logic signed [SUM_WIDTH-1:0]    sum_q, sum_d;
   logic [DATA_WIDTH-1:0]          y_q, y_d;
   logic                           out_valid_q, out_valid_d;
   logic                           in_ready_q, in_ready_d;
   logic                           busy_q, busy_d;
   logic                           ovf_q, ovf_d;
   logic signed [ACC_WIDTH-1:0]    s1_q [N_SECTIONS];
   logic signed [ACC_WIDTH-1:0]    s1_d [N_SECTIONS];
   logic signed [ACC_WIDTH-1:0]    s2_q [N_SECTIONS];
   logic signed [ACC_WIDTH-1:0]    s2_d [N_SECTIONS];
   // Coefficient slot order: b0, b1, b2, a1, a2
   logic signed [COEFF_WIDTH-1:0]  coef_q [N_SECTIONS][5];
   logic signed [COEFF_WIDTH-1:0]  coef_d [N_SECTIONS][5];

   // Shared section datapath, steered by the section counter
   logic signed [PW-1:0]          p_b0, p_b1, p_b2, p_a1, p_a2;
   logic signed [ACC_WIDTH-1:0]   v, v_shr, s1_new, s2_new;
   logic signed [DATA_WIDTH-1:0]  y_k, y_sum;
   logic                          sec_sat, sum_sat;

   always_comb begin
      p_b0  = coef_q[cnt_q][0] * x_q;
      p_b1  = coef_q[cnt_q][1] * x_q;
      p_b2  = coef_q[cnt_q][2] * x_q;
      v     = {{(ACC_WIDTH-PW){p_b0[PW-1]}}, p_b0} + s1_q[cnt_q];
      v_shr = v >>> FRAC_BITS;
      sec_sat = 1'b0;
      if (v_shr > ACC_MAX) begin
         y_k     = D_MAX;
         sec_sat = 1'b1;
      end else if (v_shr < ACC_MIN) begin
         y_k     = D_MIN;
         sec_sat = 1'b1;
      end else begin
         y_k = v_shr[DATA_WIDTH-1:0];
      end
      p_a1   = coef_q[cnt_q][3] * y_k;
      p_a2   = coef_q[cnt_q][4] * y_k;
      s1_new = {{(ACC_WIDTH-PW){p_b1[PW-1]}}, p_b1} - {{(ACC_WIDTH-PW){p_a1[PW-1]}}, p_a1} + s2_q[cnt_q];
      s2_new = {{(ACC_WIDTH-PW){p_b2[PW-1]}}, p_b2} - {{(ACC_WIDTH-PW){p_a2[PW-1]}}, p_a2};
      sum_sat = 1'b0;
      if (sum_q > SUM_MAX) begin
         y_sum   = D_MAX;
         sum_sat = 1'b1;
      end else if (sum_q < SUM_MIN) begin
         y_sum   = D_MIN;
         sum_sat = 1'b1;
      end else begin
         y_sum = sum_q[DATA_WIDTH-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      en_d        = en_q;
      sum_d       = sum_q;
      y_d         = y_q;
      out_valid_d = 1'b0;
      ovf_d       = ovf_q;
      s1_d        = s1_q;
      s2_d        = s2_q;
      coef_d      = coef_q;

      if (flush) begin
         state_d = S_IDLE;
         for (int unsigned i = 0; i < N_SECTIONS; i++) begin
            s1_d[i] = '0;
            s2_d[i] = '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  x_d     = x_in;
                  en_d    = sec_enable;
                  sum_d   = '0;
                  cnt_d   = '0;
                  state_d = S_CALC;
               end else if (coef_we && !in_valid && (32'(coef_sec) < N_SECTIONS) && (coef_sel <= 3'd4)) begin
                  coef_d[coef_sec][coef_sel] = coef_data;
               end
            end
            S_CALC: begin
               if (en_q[cnt_q]) begin
                  s1_d[cnt_q] = s1_new;
                  s2_d[cnt_q] = s2_new;
                  sum_d       = sum_q + {{(SUM_WIDTH-DATA_WIDTH){y_k[DATA_WIDTH-1]}}, y_k};
                  ovf_d       = ovf_q | sec_sat;
               end else begin
                  s1_d[cnt_q] = '0;
                  s2_d[cnt_q] = '0;
               end
               if (cnt_q == SW'(N_SECTIONS-1)) state_d = S_OUT;
               else                            cnt_d   = cnt_q + SW'(1);
            end
            S_OUT: begin
               y_d         = y_sum;
               out_valid_d = 1'b1;
               ovf_d       = ovf_q | sum_sat;
               state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      in_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         en_q        <= '0;
         sum_q       <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         for (int unsigned i = 0; i < N_SECTIONS; i++) begin
            s1_q[i] <= '0;
            s2_q[i] <= '0;
            for (int unsigned j = 0; j < 5; j++) coef_q[i][j] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         en_q        <= en_d;
         sum_q       <= sum_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         coef_q      <= coef_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y_out     = y_q;
   assign busy      = busy_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_parallel_biquad_bank.sv
// Directed bench for parallel_biquad_bank: expected outputs are queued at stimulus time
// and compared when out_valid appears.
module tb_parallel_biquad_bank;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int N  = 4;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] x_in = '0;
   logic          out_valid;
   logic [DW-1:0] y_out;
   logic [N-1:0]  sec_enable = '0;
   logic          coef_we = 1'b0;
   logic [SW-1:0] coef_sec = '0;
   logic [2:0]    coef_sel = '0;
   logic [CW-1:0] coef_data = '0;
   logic          flush = 1'b0;
   logic          busy;
   logic          ovf;

   int checks = 0;
   int fails  = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   parallel_biquad_bank #(
      .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .FRAC_BITS(14), .N_SECTIONS(N)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
      .out_valid(out_valid), .y_out(y_out), .sec_enable(sec_enable), .coef_we(coef_we),
      .coef_sec(coef_sec), .coef_sel(coef_sel), .coef_data(coef_data), .flush(flush),
      .busy(busy), .ovf(ovf)
   );

   task automatic chk(input string tag, input longint obs, input longint expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic wr(input int sec, input int sel, input int data);
      coef_we = 1'b1; coef_sec = SW'(sec); coef_sel = 3'(sel); coef_data = CW'(data);
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   // poke: attempt a b0 write both at the accept edge and during CALC; both must be ignored
   task automatic send(input string tag, input int x, input logic [N-1:0] m, input int expv,
                       input bit poke, input bit chk_ready);
      int  cnt;
      bit  acc;
      int  e;
      exp_q.push_back(expv);
      x_in = DW'(x); sec_enable = m; in_valid = 1'b1;
      if (poke) begin
         coef_we = 1'b1; coef_sec = '0; coef_sel = 3'd0; coef_data = CW'(8192);
      end
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = in_ready;
         @(negedge clk);
      end
      in_valid = 1'b0;
      coef_we  = 1'b0;
      chk({tag, "_accept"}, acc, 1);
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         if (chk_ready) chk({tag, "_in_ready_low"}, in_ready, 0);
         coef_we = (poke && cnt == 1);
         @(negedge clk);
         cnt++;
      end
      coef_we = 1'b0;
      chk({tag, "_latency"}, cnt, N + 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 99999;
      chk(tag, $signed(y_out), e);
   endtask

   initial begin
      int accepts;
      int outs;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y_out", y_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      // passthrough on section 0
      wr(0, 0, 16384);
      send("pass", 1000, 4'b0001, 1000, 1'b0, 1'b1);

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      x_in = DW'(500); sec_enable = 4'b0001; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_y_out", y_out, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ovf", ovf, 0);
      chk("arst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_rel_in_ready", in_ready, 1);
      outs = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) outs++;
         @(negedge clk);
      end
      chk("arst_no_out_valid", outs, 0);
      send("zero_coefs", 1000, 4'b1111, 0, 1'b0, 1'b0);

      // FIR taps then single pole at 0.5
      wr(0, 0, 16384);
      wr(0, 1, 16384);
      send("fir0", 1000, 4'b0001, 1000, 1'b0, 1'b0);
      send("fir1", 0, 4'b0001, 1000, 1'b0, 1'b0);
      send("fir2", 0, 4'b0001, 0, 1'b0, 1'b0);
      wr(0, 1, 0);
      wr(0, 3, -8192);
      send("pole0", 1000, 4'b0001, 1000, 1'b0, 1'b0);
      send("pole1", 0, 4'b0001, 500, 1'b0, 1'b0);
      send("pole2", 0, 4'b0001, 250, 1'b0, 1'b0);
      send("pole3", 0, 4'b0001, 125, 1'b0, 1'b0);

      // parallel sum, disable clears state, re-enable starts fresh
      wr(0, 3, 0);
      pulse_flush();
      chk("idle_flush_busy", busy, 0);
      wr(0, 0, 8192);
      wr(1, 0, 8192);
      wr(1, 1, 16384);
      send("par_sum", 1000, 4'b0011, 1000, 1'b0, 1'b0);
      send("par_dis", 1000, 4'b0001, 500, 1'b0, 1'b0);
      send("par_reen", 0, 4'b0011, 0, 1'b0, 1'b0);

      // saturation and sticky ovf
      wr(1, 1, 0);
      for (int s = 0; s < N; s++) wr(s, 0, 16384);
      chk("ovf_pre", ovf, 0);
      send("sat_pos", 30000, 4'b1111, 32767, 1'b0, 1'b0);
      chk("ovf_set", ovf, 1);
      send("sat_neg", -30000, 4'b1111, -32768, 1'b0, 1'b0);
      send("small", 10, 4'b1111, 40, 1'b0, 1'b0);
      chk("ovf_sticky", ovf, 1);

      // coefficient writes while busy or while in_valid is high are dropped
      for (int s = 1; s < N; s++) wr(s, 0, 0);
      send("we_busy0", 1000, 4'b0001, 1000, 1'b1, 1'b0);
      send("we_busy1", 1000, 4'b0001, 1000, 1'b0, 1'b0);

      // in_valid held high: one accept per IDLE window
      @(negedge clk);
      x_in = DW'(200); sec_enable = 4'b0001; in_valid = 1'b1;
      accepts = 0; outs = 0;
      for (int i = 0; i < 12; i++) begin
         if (in_ready) accepts++;
         if (out_valid) outs++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) outs++;
         @(negedge clk);
      end
      chk("held_accepts", accepts, 2);
      chk("held_outs", outs, 2);
      chk("held_y", $signed(y_out), 200);

      // flush mid-CALC aborts the sample and zeroes state
      wr(0, 3, -8192);
      x_in = DW'(1000); sec_enable = 4'b0001; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      pulse_flush();
      chk("flush_busy", busy, 0);
      chk("flush_in_ready", in_ready, 1);
      outs = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) outs++;
         @(negedge clk);
      end
      chk("flush_no_out", outs, 0);
      chk("flush_y_kept", $signed(y_out), 200);
      send("fl_imp0", 1000, 4'b0001, 1000, 1'b0, 1'b0);
      send("fl_imp1", 0, 4'b0001, 500, 1'b0, 1'b0);
      send("fl_imp2", 0, 4'b0001, 250, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
